// File: rtl/sdfm_filter.sv
// Sigma-delta modulator decimation filter: sinc1/2/3 CIC with programmable OSR,
// settling suppression and an optional acknowledge/overrun output handshake.
module sdfm_filter (
    input  logic        SYSCLK,
    input  logic        SYSRSTn,
    input  logic        bit_in,
    input  logic        bit_stb,
    input  logic        reg_filten,
    input  logic        reg_filtask,
    input  logic [1:0]  reg_filtst,
    input  logic [7:0]  reg_filtdec,
    input  logic        data_ack,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        data_ovr
);

    logic        en_q;
    logic [1:0]  st_q;
    logic [7:0]  dec_q;
    logic [7:0]  cnt_q;
    logic [1:0]  settle_q;
    logic [31:0] i1_q, i2_q, i3_q;
    logic [31:0] d1_q, d2_q, d3_q;

    logic [31:0] i1_nxt, i2_nxt, i3_nxt;
    logic [31:0] comb_in, c1, c2, c3, comb_out;
    logic [1:0]  order;
    logic        dec_evt;
    logic        settled;
    logic        publish;

    // Each integrator accumulates the previous stage's pre-update value.
    assign i1_nxt = i1_q + {31'd0, bit_in};
    assign i2_nxt = i2_q + i1_q;
    assign i3_nxt = i3_q + i2_q;

    always_comb begin
        order    = 2'd3;
        comb_in  = i3_nxt;
        comb_out = c3;
        case (st_q)
            2'd0: begin order = 2'd1; comb_in = i1_nxt; comb_out = c1; end
            2'd1: begin order = 2'd2; comb_in = i2_nxt; comb_out = c2; end
            default: ;
        endcase
    end

    assign c1 = comb_in - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    assign dec_evt = en_q && bit_stb && (cnt_q == dec_q);
    assign settled = (settle_q >= (order - 2'd1));
    assign publish = dec_evt && settled;

    // NOTE: every register here, datapath included, sits on the async reset so that
    // outputs and filter history are known the instant SYSRSTn falls.
    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            en_q       <= 1'b0;
            st_q       <= 2'd0;
            dec_q      <= 8'd0;
            cnt_q      <= 8'd0;
            settle_q   <= 2'd0;
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            data_ovr   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            en_q <= reg_filten;
            if (!en_q) begin
                // Shadows track the registers while idle; the value present at enable sticks.
                st_q       <= reg_filtst;
                dec_q      <= reg_filtdec;
                cnt_q      <= 8'd0;
                settle_q   <= 2'd0;
                i1_q       <= '0;
                i2_q       <= '0;
                i3_q       <= '0;
                d1_q       <= '0;
                d2_q       <= '0;
                d3_q       <= '0;
                data_out   <= '0;
                data_valid <= 1'b0;
                data_ovr   <= 1'b0;
            end else begin
                if (bit_stb) begin
                    i1_q  <= i1_nxt;
                    i2_q  <= i2_nxt;
                    i3_q  <= i3_nxt;
                    cnt_q <= dec_evt ? 8'd0 : cnt_q + 8'd1;
                end
                if (dec_evt) begin
                    d1_q <= comb_in;
                    d2_q <= c1;
                    d3_q <= c2;
                    if (!settled)
                        settle_q <= settle_q + 2'd1;
                end

                if (reg_filtask) begin
                    if (publish) begin
                        data_out   <= comb_out;
                        data_valid <= 1'b1;
                        if (data_valid && !data_ack)
                            data_ovr <= 1'b1;
                    end else if (data_ack) begin
                        data_valid <= 1'b0;
                    end
                end else begin
                    data_valid <= publish;
                    if (publish)
                        data_out <= comb_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdfm_filter.sv
// Self-checking bench for sdfm_filter: directed scenarios with literal results plus
// randomized traffic compared every cycle against a finite-difference reference model.
module tb_sdfm_filter;

    logic        SYSCLK = 1'b0;
    logic        SYSRSTn = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_stb = 1'b0;
    logic        reg_filten = 1'b0;
    logic        reg_filtask = 1'b0;
    logic [1:0]  reg_filtst = 2'd0;
    logic [7:0]  reg_filtdec = 8'd0;
    logic        data_ack = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ovr;

    int n_checks = 0;
    int n_pass   = 0;

    sdfm_filter dut (
        .SYSCLK     (SYSCLK),
        .SYSRSTn    (SYSRSTn),
        .bit_in     (bit_in),
        .bit_stb    (bit_stb),
        .reg_filten (reg_filten),
        .reg_filtask(reg_filtask),
        .reg_filtst (reg_filtst),
        .reg_filtdec(reg_filtdec),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ovr   (data_ovr)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Integrator-k value sampled at each decimation point; output is the k-th
    // backward difference of those samples (missing history counts as zero).
    logic        m_en = 1'b0;
    logic [1:0]  m_st = 2'd0;
    logic [7:0]  m_dec = 8'd0;
    int unsigned s1 = 0, s2 = 0, s3 = 0;
    int          nstb = 0;
    int unsigned hist[$];
    logic [31:0] exp_out = '0;
    logic        exp_valid = 1'b0;
    logic        exp_ovr = 1'b0;

    function automatic int binom(input int n, input int r);
        int c = 1;
        for (int i = 0; i < r; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    function automatic int unsigned kth_diff(input int k);
        int unsigned acc = 0;
        for (int j = 0; j <= k; j++) begin
            int unsigned term;
            term = (j < hist.size()) ? hist[j] * int'(binom(k, j)) : 0;
            if (j % 2 == 0) acc = acc + term;
            else            acc = acc - term;
        end
        return acc;
    endfunction

    task automatic model_clear();
        s1 = 0; s2 = 0; s3 = 0; nstb = 0;
        hist.delete();
        exp_out = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic model_step();
        bit          pub;
        int unsigned v;
        int          k;
        pub = 1'b0;
        v   = 0;
        k   = (m_st == 2'd0) ? 1 : (m_st == 2'd1) ? 2 : 3;
        if (!m_en) begin
            model_clear();
            m_st  = reg_filtst;
            m_dec = reg_filtdec;
        end else begin
            if (bit_stb) begin
                s3 = s3 + s2;
                s2 = s2 + s1;
                s1 = s1 + 32'(bit_in);
                nstb++;
                if (nstb == int'(m_dec) + 1) begin
                    nstb = 0;
                    hist.push_front(k == 1 ? s1 : (k == 2 ? s2 : s3));
                    if (hist.size() > 4) void'(hist.pop_back());
                    if (hist.size() >= k) begin
                        pub = 1'b1;
                        v   = kth_diff(k);
                    end
                end
            end
            if (reg_filtask) begin
                if (pub) begin
                    if (exp_valid && !data_ack) exp_ovr = 1'b1;
                    exp_out   = v;
                    exp_valid = 1'b1;
                end else if (data_ack) begin
                    exp_valid = 1'b0;
                end
            end else begin
                exp_valid = pub;
                if (pub) exp_out = v;
            end
        end
        m_en = reg_filten;
    endtask

    initial forever begin
        @(posedge SYSCLK or negedge SYSRSTn);
        if (!SYSRSTn) begin
            model_clear();
            m_en = 1'b0; m_st = 2'd0; m_dec = 8'd0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge SYSCLK);
        if (SYSRSTn) begin
            check("cyc_data_valid", data_valid, exp_valid);
            check("cyc_data_out",   data_out,   exp_out);
            check("cyc_data_ovr",   data_ovr,   exp_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic b, input logic ack);
        @(negedge SYSCLK);
        bit_in   = b;
        bit_stb  = 1'b1;
        data_ack = ack;
    endtask

    task automatic strobes_ones(input int n);
        for (int i = 0; i < n; i++) strobe(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge SYSCLK);
            bit_stb  = 1'b0;
            data_ack = 1'b0;
        end
    endtask

    task automatic disable_filter();
        @(negedge SYSCLK);
        reg_filten = 1'b0;
        bit_stb    = 1'b0;
        data_ack   = 1'b0;
        idle(2);
    endtask

    task automatic enable_filter(input logic [1:0] st, input logic [7:0] dec, input logic ask);
        @(negedge SYSCLK);
        reg_filtst  = st;
        reg_filtdec = dec;
        reg_filtask = ask;
        reg_filten  = 1'b1;
        bit_stb     = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1;
        check("reset_data_out",   data_out,   32'd0);
        check("reset_data_valid", data_valid, 32'd0);
        check("reset_data_ovr",   data_ovr,   32'd0);
        #20 SYSRSTn = 1'b1;
        idle(2);

        // sinc1, OSR 16, all ones
        enable_filter(2'd0, 8'd15, 1'b0);
        strobes_ones(16); idle(1);
        check("sinc1_first_valid", data_valid, 32'd1);
        check("sinc1_first_out",   data_out,   32'd16);
        idle(1);
        check("sinc1_pulse_drop", data_valid, 32'd0);
        strobes_ones(16); idle(1);
        check("sinc1_second_out", data_out, 32'd16);
        disable_filter();

        // sinc3, OSR 256, all ones
        enable_filter(2'd2, 8'd255, 1'b0);
        strobes_ones(512); idle(1);
        check("sinc3_settle_valid", data_valid, 32'd0);
        check("sinc3_settle_out",   data_out,   32'd0);
        strobes_ones(256); idle(1);
        check("sinc3_third_valid", data_valid, 32'd1);
        check("sinc3_third_out",   data_out,   32'h0100_0000);
        disable_filter();

        // sinc2, OSR 4, alternating 1,0
        enable_filter(2'd1, 8'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); end
        idle(1);
        check("sinc2_first_suppressed", data_valid, 32'd0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) begin strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); end
            idle(1);
            check("sinc2_valid", data_valid, 32'd1);
            check("sinc2_out",   data_out,   32'd8);
        end
        disable_filter();

        // ack mode: hold, overrun, coincident ack
        enable_filter(2'd0, 8'd7, 1'b1);
        strobes_ones(8); idle(1);
        check("ack_valid",    data_valid, 32'd1);
        check("ack_out",      data_out,   32'd8);
        idle(3);
        check("ack_hold",     data_valid, 32'd1);
        strobes_ones(8); idle(1);
        check("ovr_set",      data_ovr,   32'd1);
        check("ovr_valid",    data_valid, 32'd1);
        disable_filter();
        check("ovr_cleared",  data_ovr,   32'd0);
        enable_filter(2'd0, 8'd7, 1'b1);
        strobes_ones(8); idle(1);
        strobes_ones(7); strobe(1'b1, 1'b1); idle(1);
        check("coinc_valid",  data_valid, 32'd1);
        check("coinc_no_ovr", data_ovr,   32'd0);
        @(negedge SYSCLK); data_ack = 1'b1;
        idle(1);
        check("ack_clears",   data_valid, 32'd0);
        disable_filter();

        // enable dropped mid-period; filtdec changed while enabled
        enable_filter(2'd0, 8'd7, 1'b0);
        strobes_ones(5);
        disable_filter();
        check("drop_out", data_out, 32'd0);
        enable_filter(2'd0, 8'd7, 1'b0);
        @(negedge SYSCLK); reg_filtdec = 8'd2;
        strobes_ones(7); idle(1);
        check("reen_no_early_out", data_out, 32'd0);
        strobes_ones(1); idle(1);
        check("reen_valid", data_valid, 32'd1);
        check("reen_out",   data_out,   32'd8);
        disable_filter();

        // async reset mid-period with a held sample
        enable_filter(2'd0, 8'd7, 1'b1);
        strobes_ones(8); idle(1);
        check("prerst_valid", data_valid, 32'd1);
        strobes_ones(3);
        @(posedge SYSCLK); #2;
        SYSRSTn = 1'b0;
        #1;
        check("async_rst_out",   data_out,   32'd0);
        check("async_rst_valid", data_valid, 32'd0);
        check("async_rst_ovr",   data_ovr,   32'd0);
        reg_filten = 1'b0;
        bit_stb    = 1'b0;
        #20 SYSRSTn = 1'b1;
        idle(2);

        // randomized traffic
        for (int seg = 0; seg < 12; seg++) begin
            logic [7:0] dec;
            dec = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 20));
            disable_filter();
            enable_filter(2'($urandom_range(0, 3)), dec, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 500; c++) begin
                @(negedge SYSCLK);
                bit_stb  = ($urandom_range(0, 3) != 0);
                bit_in   = 1'($urandom_range(0, 1));
                data_ack = reg_filtask && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 99) == 0) reg_filtdec = 8'($urandom);
                if ($urandom_range(0, 99) == 0) reg_filtst  = 2'($urandom);
                if ($urandom_range(0, 299) == 0) reg_filten = 1'b0;
                else if (!reg_filten && $urandom_range(0, 1) == 0) reg_filten = 1'b1;
            end
        end
        disable_filter();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdfm_filter.md
SDFM_FILTER -- requirements
Module: sdfm_filter

Interface
REQ-001 SHALL have port SYSCLK  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port SYSRSTn  input  1  system reset, asynchronous, active-low.
REQ-003 SHALL have port bit_in  input  1  modulator bit from input stage; 1 counts +1, 0 counts 0.
REQ-004 SHALL have port bit_stb  input  1  one-cycle strobe marking bit_in valid.
REQ-005 SHALL have port reg_filten  input  1  filter enable (FEN).
REQ-006 SHALL have port reg_filtask  input  1  acknowledge mode enable (AEN).
REQ-007 SHALL have port reg_filtst  input  2  structure: 00 sinc1, 01 sinc2, 10 sinc3, 11 reserved, treated as sinc3.
REQ-008 SHALL have port reg_filtdec  input  8  decimation; OSR = reg_filtdec+1 (1..256).
REQ-009 SHALL have port data_ack  input  1  consumer acknowledge, one cycle.
REQ-010 SHALL have port data_out  output  32  filtered sample, unsigned, zero-extended.
REQ-011 SHALL have port data_valid  output  1  sample available.
REQ-012 SHALL have port data_ovr  output  1  sticky overrun flag.
REQ-013 SHALL use one clock (SYSCLK) and an asynchronous active-low reset (SYSRSTn).

Function
REQ-014 SHALL hold internal enable en_q = registered reg_filten; bit_stb in the cycle reg_filten rises is ignored.
REQ-015 SHALL capture reg_filtst and reg_filtdec into shadows on the en_q 0->1 edge; changes while enabled ignored until the next enable.
REQ-016 SHALL, while en_q=0, synchronously clear integrators, comb delays, decimation counter, settle counter, data_out, data_valid, data_ovr.
REQ-017 SHALL, on each enabled bit_stb, update the integrator chain modulo 2^32: i1+=bit_in, i2+=i1(old), i3+=i2(old).
REQ-018 SHALL count bit_stb 0..D (D = shadow filtdec); at the strobe where count==D, wrap to 0 and fire a decimation event; D=0 fires on every strobe.
REQ-019 SHALL, on a decimation event, run k comb stages (k = order 1/2/3) on integrator k's post-update value: c_j = in_j - dly_j, dly_j <= in_j, modulo 2^32.
REQ-020 SHALL produce data_out = comb stage k output, registered one SYSCLK after the decimation event; full scale = OSR^k (max 2^24).
REQ-021 SHALL suppress the first k-1 decimation results after enable (settling); data_out/data_valid untouched by suppressed results.
REQ-022 SHALL, when reg_filtask=0, pulse data_valid for exactly one cycle per published sample; data_ack ignored; data_ovr stays 0.
REQ-023 SHALL, when reg_filtask=1, hold data_valid high from publish until a cycle with data_ack=1; data_ack while data_valid=0 ignored.
REQ-024 SHALL, in ack mode, on publish while data_valid=1 and data_ack=0, overwrite data_out, keep data_valid=1, and set data_ovr.
REQ-025 SHALL, in ack mode, on publish coincident with data_ack, load the new sample, keep data_valid=1, and not set data_ovr.
REQ-026 SHALL keep data_ovr set until en_q=0 or reset.
REQ-027 SHALL, if reg_filten drops mid-decimation, discard the partial period; re-enable restarts settling from zero.

Reset
REQ-028 SHALL on SYSRSTn=0 asynchronously clear data_out=0, data_valid=0, data_ovr=0, en_q=0, shadows=0, and all integrators, combs and counters.
REQ-029 SHALL resume only after enable is seen after reset deassertion, per REQ-014.

Verification
REQ-030 SHALL cover: sinc1, filtdec=15, bit_in=1 on every strobe -> first sample data_out=16, then 16 every 16 strobes; data_valid one-cycle pulses.
REQ-031 SHALL cover: sinc3, filtdec=255, all ones -> first two results suppressed, third data_out=0x0100_0000, one cycle after the 768th strobe.
REQ-032 SHALL cover: sinc2, filtdec=3, bit_in alternating 1,0 -> second decimation result published, data_out=8, steady thereafter.
REQ-033 SHALL cover: ack mode, sinc1, filtdec=7, no data_ack -> data_valid stays 1, second publish sets data_ovr; ack coincident with a publish -> no overrun set.
REQ-034 SHALL cover: reg_filten dropped mid-period then raised -> outputs cleared, next sample only after a full new period; reg_filtdec changed while enabled has no effect.
REQ-035 SHALL cover: SYSRSTn asserted mid-period with data_valid=1 in ack mode -> all outputs 0 immediately, independent of SYSCLK.
